// File: rtl/base_ram_1r1w.sv
// Storage for base_fifo_vr: width x depth entries, one synchronous write
// port and one asynchronous read port. Contents are never reset.
module base_ram_1r1w #(
    parameter int width = 8,
    parameter int depth = 4,
    parameter int aw    = $clog2(depth)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [aw-1:0]    wr_addr,
    input  logic [0:width-1] wr_data,
    input  logic [aw-1:0]    rd_addr,
    output logic [0:width-1] rd_data
);

    logic [0:width-1] mem_reg [depth];

    // Write the addressed entry on a push; other entries hold their value.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read so the head entry falls through to the output.
    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/base_fifo_vr.sv
// base_fifo_vr: first-word-fall-through valid/ready FIFO. Ready and valid
// are functions of the registered count only, so neither side sees a
// combinational path from the other. No empty bypass: a pushed word is
// visible one edge later.
module base_fifo_vr #(
    parameter int width     = 8,
    parameter int depth     = 4,
    parameter int afull_lvl = depth - 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_v,
    input  logic [0:width-1]          i_d,
    output logic                      i_r,
    output logic                      o_v,
    output logic [0:width-1]          o_d,
    input  logic                      o_r,
    output logic [$clog2(depth):0]    o_cnt,
    output logic                      o_afull
);

    localparam int aw = $clog2(depth);

    localparam logic [aw:0]   full_cnt  = (aw + 1)'(depth);
    localparam logic [aw:0]   afull_cnt = (aw + 1)'(afull_lvl);
    localparam logic [aw:0]   cnt_one   = (aw + 1)'(1);
    localparam logic [aw-1:0] ptr_one   = aw'(1);

    logic [aw-1:0] wr_ptr_reg, wr_ptr_next;
    logic [aw-1:0] rd_ptr_reg, rd_ptr_next;
    logic [aw:0]   cnt_reg,    cnt_next;
    logic          push;
    logic          pop;

    // Handshake qualifiers; both sides see only registered-state outputs.
    assign i_r     = (cnt_reg != full_cnt);
    assign o_v     = (cnt_reg != '0);
    assign o_cnt   = cnt_reg;
    assign o_afull = (cnt_reg >= afull_cnt);

    assign push = i_v & i_r;
    assign pop  = o_v & o_r;

    // Next-state for pointers and occupancy; pointers wrap naturally at depth.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        cnt_next    = cnt_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + ptr_one;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + ptr_one;
        end
        case ({push, pop})
            2'b10:   cnt_next = cnt_reg + cnt_one;
            2'b01:   cnt_next = cnt_reg - cnt_one;
            default: cnt_next = cnt_reg;
        endcase
    end

    // Pointer and count state, cleared asynchronously so entries are discarded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            cnt_reg    <= cnt_next;
        end
    end

    base_ram_1r1w #(
        .width (width),
        .depth (depth),
        .aw    (aw)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg),
        .wr_data (i_d),
        .rd_addr (rd_ptr_reg),
        .rd_data (o_d)
    );

endmodule

// File: tb/tb_base_fifo_vr.sv
// Directed and randomised back-pressure checks for base_fifo_vr (depth 4, width 8).
module tb_base_fifo_vr;

    logic       clk;
    logic       reset;
    logic       i_v;
    logic [0:7] i_d;
    logic       i_r;
    logic       o_v;
    logic [0:7] o_d;
    logic       o_r;
    logic [2:0] o_cnt;
    logic       o_afull;

    int checks   = 0;
    int failures = 0;

    base_fifo_vr #(.width(8), .depth(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_v     (i_v),
        .i_d     (i_d),
        .i_r     (i_r),
        .o_v     (o_v),
        .o_d     (o_d),
        .o_r     (o_r),
        .o_cnt   (o_cnt),
        .o_afull (o_afull)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] fill_tab [4];
    logic [7:0] exp_q [$];
    logic [7:0] v;
    int         pushes;
    int         pops;
    logic       rv;
    logic       rr;

    initial begin
        fill_tab[0] = 8'h11; fill_tab[1] = 8'h22;
        fill_tab[2] = 8'h33; fill_tab[3] = 8'h44;
        reset = 1'b0; i_v = 1'b0; i_d = 8'h00; o_r = 1'b0;

        // Reset state
        #2;
        chk("rst_cnt",   32'(o_cnt),   32'd0);
        chk("rst_ov",    32'(o_v),     32'd0);
        chk("rst_ir",    32'(i_r),     32'd1);
        chk("rst_afull", 32'(o_afull), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        $display("reset released");

        // Latency: 0xA5 visible only after the pushing edge
        i_v = 1'b1; i_d = 8'hA5;
        #1 chk("lat_ov_before", 32'(o_v), 32'd0);
        tick();
        i_v = 1'b0;
        chk("lat_ov_after", 32'(o_v), 32'd1);
        chk("lat_od",       32'(o_d), 32'hA5);
        chk("lat_cnt",      32'(o_cnt), 32'd1);
        $display("latency push 0xA5 seen=0x%0h", o_d);
        o_r = 1'b1; tick(); o_r = 1'b0;
        chk("lat_empty_cnt", 32'(o_cnt), 32'd0);

        // Fill and drain
        for (int k = 0; k < 4; k++) begin
            i_v = 1'b1; i_d = fill_tab[k];
            tick();
            chk("fill_cnt",   32'(o_cnt),   32'(k + 1));
            chk("fill_afull", 32'(o_afull), (k + 1 >= 3) ? 32'd1 : 32'd0);
            $display("fill push 0x%0h cnt=%0d", fill_tab[k], o_cnt);
        end
        i_v = 1'b0;
        chk("full_ir", 32'(i_r), 32'd0);
        o_r = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_od", 32'(o_d), 32'(fill_tab[k]));
            $display("drain pop 0x%0h", o_d);
            tick();
        end
        o_r = 1'b0;
        chk("drain_cnt",   32'(o_cnt),   32'd0);
        chk("drain_ov",    32'(o_v),     32'd0);
        chk("drain_afull", 32'(o_afull), 32'd0);

        // Full with simultaneous push and pop: pop only, then held push lands
        for (int k = 0; k < 4; k++) begin
            i_v = 1'b1; i_d = 8'(8'h61 + k); tick();
        end
        i_d = 8'h99; o_r = 1'b1;
        chk("fp_ir", 32'(i_r), 32'd0);
        tick();
        chk("fp_cnt_pop", 32'(o_cnt), 32'd3);
        chk("fp_head",    32'(o_d),   32'h62);
        o_r = 1'b0;
        tick();
        i_v = 1'b0;
        chk("fp_cnt_push", 32'(o_cnt), 32'd4);
        $display("full+pop cnt=%0d", o_cnt);
        o_r = 1'b1;
        chk("fp_d0", 32'(o_d), 32'h62); tick();
        chk("fp_d1", 32'(o_d), 32'h63); tick();
        chk("fp_d2", 32'(o_d), 32'h64); tick();
        chk("fp_d3", 32'(o_d), 32'h99); tick();
        o_r = 1'b0;
        chk("fp_empty", 32'(o_cnt), 32'd0);

        // Simultaneous push/pop at occupancy 2 for 10 cycles (pointers wrap)
        exp_q = {};
        i_v = 1'b1; i_d = 8'h01; exp_q.push_back(8'h01); tick();
        i_d = 8'h02; exp_q.push_back(8'h02); tick();
        o_r = 1'b1;
        for (int c = 0; c < 10; c++) begin
            i_d = 8'(8'h10 + c);
            exp_q.push_back(i_d);
            v = exp_q.pop_front();
            chk("pp_od", 32'(o_d), 32'(v));
            tick();
            chk("pp_cnt", 32'(o_cnt), 32'd2);
            $display("pushpop in=0x%0h out=0x%0h", i_d, v);
        end
        i_v = 1'b0;
        while (exp_q.size() > 0) begin
            v = exp_q.pop_front();
            chk("pp_tail", 32'(o_d), 32'(v));
            tick();
        end
        o_r = 1'b0;
        chk("pp_empty", 32'(o_cnt), 32'd0);

        // Mid-operation asynchronous reset
        for (int k = 0; k < 3; k++) begin
            i_v = 1'b1; i_d = 8'(8'h71 + k); tick();
        end
        i_v = 1'b0;
        chk("mr_cnt_pre", 32'(o_cnt), 32'd3);
        #3 reset = 1'b0;
        #1;
        chk("mr_cnt",   32'(o_cnt),   32'd0);
        chk("mr_ov",    32'(o_v),     32'd0);
        chk("mr_ir",    32'(i_r),     32'd1);
        chk("mr_afull", 32'(o_afull), 32'd0);
        #1 reset = 1'b1;
        i_v = 1'b1; i_d = 8'h5A; tick(); i_v = 1'b0;
        chk("mr_ov_after", 32'(o_v),   32'd1);
        chk("mr_od",       32'(o_d),   32'h5A);
        chk("mr_cnt_one",  32'(o_cnt), 32'd1);
        $display("after reset push 0x5A seen=0x%0h", o_d);
        o_r = 1'b1; tick(); o_r = 1'b0;
        chk("mr_no_stale", 32'(o_v), 32'd0);

        // Random back-pressure against a queue scoreboard
        exp_q = {};
        pushes = 0;
        pops = 0;
        for (int c = 0; c < 1000; c++) begin
            rv = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            i_v = rv; o_r = rr; i_d = 8'($urandom_range(0, 255));
            chk("rnd_ir", 32'(i_r), (exp_q.size() != 4) ? 32'd1 : 32'd0);
            chk("rnd_ov", 32'(o_v), (exp_q.size() != 0) ? 32'd1 : 32'd0);
            if (exp_q.size() != 0) begin
                chk("rnd_od", 32'(o_d), 32'(exp_q[0]));
            end
            // Decide both handshakes from the pre-edge occupancy
            if (rr && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                pops = pops + 1;
                if (rv && exp_q.size() + 1 != 4) begin
                    exp_q.push_back(i_d);
                    pushes = pushes + 1;
                end
            end else if (rv && exp_q.size() != 4) begin
                exp_q.push_back(i_d);
                pushes = pushes + 1;
            end
            tick();
            chk("rnd_cnt", 32'(o_cnt), 32'(pushes - pops));
        end
        i_v = 1'b0; o_r = 1'b0;
        $display("random phase pushes=%0d pops=%0d", pushes, pops);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
